cache_mem_responder: RTL and testbench

//   Responder side of the cache refill/writeback interface: accepts rd_req/wr_req

---
 rtl/cache_mem_responder_if.sv | 29 ++
 rtl/cache_mem_responder.sv | 140 ++++++++++++++
 tb/tb_cache_mem_responder.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_mem_responder_if.sv
// Cache refill/writeback bus between one cache (master) and its memory responder (slave).
// The cache drives the requests; the responder drives the ready and return-beat signals.
interface cache_mem_responder_if;
    logic         rd_req;
    logic [2:0]   rd_type;
    logic [31:0]  rd_addr;
    logic         rd_rdy;
    logic         ret_valid;
    logic         ret_last;
    logic [31:0]  ret_data;
    logic         wr_req;
    logic [2:0]   wr_type;
    logic [31:0]  wr_addr;
    logic [3:0]   wr_wstrb;
    logic [127:0] wr_data;
    logic         wr_rdy;

    modport master (
        output rd_req, rd_type, rd_addr,
        output wr_req, wr_type, wr_addr, wr_wstrb, wr_data,
        input  rd_rdy, ret_valid, ret_last, ret_data, wr_rdy
    );

    modport slave (
        input  rd_req, rd_type, rd_addr,
        input  wr_req, wr_type, wr_addr, wr_wstrb, wr_data,
        output rd_rdy, ret_valid, ret_last, ret_data, wr_rdy
    );
endinterface

// File: rtl/cache_mem_responder.sv
// Memory endpoint for a cache: services line/word reads and writes from a word-addressed RAM,
// returning read data as fixed-latency 32-bit beats.
module cache_mem_responder #(
    parameter int ADDR_W     = 12,
    parameter int RD_LATENCY = 2,
    parameter int WR_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 resetn,
    cache_mem_responder_if.slave bus
);
    localparam int         ROW_W     = ADDR_W - 2;
    localparam int         ROWS      = 1 << ROW_W;
    localparam logic [3:0] RD_LAST   = 4'(RD_LATENCY - 1);
    localparam logic [3:0] WR_LAST   = 4'((WR_LATENCY > 0) ? (WR_LATENCY - 1) : 0);
    localparam logic [2:0] TYPE_LINE = 3'b100;

    typedef enum logic [1:0] {IDLE, RD_WAIT, RD_BURST, WR_WAIT} state_t;

    state_t             r_state;
    logic [3:0]         r_lat;
    logic [1:0]         r_beat;
    logic               r_rd_line;
    logic [1:0]         r_rd_bank;
    logic [ROW_W-1:0]   r_rd_row;
    logic               r_ret_valid;
    logic               r_ret_last;
    logic [31:0]        r_ret_data;

    // RAM split into four word banks so a whole line is written in one cycle.
    logic [31:0]        r_mem [4][ROWS];

    logic               w_idle;
    logic               w_wr_acc;
    logic               w_rd_acc;
    logic               w_wr_line;
    logic [1:0]         w_wr_bank;
    logic [ROW_W-1:0]   w_wr_row;
    logic [1:0]         w_rd_bank_sel;
    logic [31:0]        w_rd_word;
    logic               w_unused;

    assign w_idle    = resetn && (r_state == IDLE);
    assign w_wr_acc  = w_idle && bus.wr_req;
    // A simultaneous write wins; the read waits for the next IDLE cycle.
    assign w_rd_acc  = w_idle && bus.rd_req && !bus.wr_req;

    assign bus.wr_rdy    = w_idle;
    assign bus.rd_rdy    = w_idle && !bus.wr_req;
    assign bus.ret_valid = r_ret_valid;
    assign bus.ret_last  = r_ret_last;
    assign bus.ret_data  = r_ret_data;

    assign w_wr_line = (bus.wr_type == TYPE_LINE);
    assign w_wr_bank = bus.wr_addr[3:2];
    assign w_wr_row  = bus.wr_addr[ADDR_W+1:4];

    assign w_rd_bank_sel = r_rd_line ? r_beat : r_rd_bank;
    assign w_rd_word     = r_mem[w_rd_bank_sel][r_rd_row];

    // Address bits above the RAM and the byte offset are ignored (aliasing / aligned word).
    assign w_unused = ^{bus.rd_addr[31:ADDR_W+2], bus.rd_addr[1:0],
                        bus.wr_addr[31:ADDR_W+2], bus.wr_addr[1:0]};

    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            for (int b = 0; b < 4; b++) begin
                if (w_wr_line) begin
                    r_mem[b][w_wr_row] <= bus.wr_data[32*b +: 32];
                end else if (w_wr_bank == 2'(b)) begin
                    for (int j = 0; j < 4; j++) begin
                        if (bus.wr_wstrb[j]) begin
                            r_mem[b][w_wr_row][8*j +: 8] <= bus.wr_data[8*j +: 8];
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state     <= IDLE;
            r_lat       <= '0;
            r_beat      <= '0;
            r_ret_valid <= 1'b0;
            r_ret_last  <= 1'b0;
            r_ret_data  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_wr_acc) begin
                        r_lat <= '0;
                        if (WR_LATENCY != 0) r_state <= WR_WAIT;
                    end else if (w_rd_acc) begin
                        r_rd_line <= (bus.rd_type == TYPE_LINE);
                        r_rd_bank <= bus.rd_addr[3:2];
                        r_rd_row  <= bus.rd_addr[ADDR_W+1:4];
                        r_lat     <= '0;
                        r_beat    <= '0;
                        r_state   <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (r_lat == RD_LAST) begin
                        r_ret_valid <= 1'b1;
                        r_ret_data  <= w_rd_word;
                        r_ret_last  <= !r_rd_line;
                        r_beat      <= r_rd_line ? 2'd1 : 2'd0;
                        r_lat       <= '0;
                        r_state     <= RD_BURST;
                    end else begin
                        r_lat <= r_lat + 4'd1;
                    end
                end
                RD_BURST: begin
                    if (r_ret_last) begin
                        r_ret_valid <= 1'b0;
                        r_ret_last  <= 1'b0;
                        r_state     <= IDLE;
                    end else begin
                        // Beat counter wraps 3 -> 0 as the final beat issues.
                        r_ret_data <= w_rd_word;
                        r_ret_last <= (r_beat == 2'd3);
                        r_beat     <= r_beat + 2'd1;
                    end
                end
                WR_WAIT: begin
                    if (r_lat == WR_LAST) begin
                        r_lat   <= '0;
                        r_state <= IDLE;
                    end else begin
                        r_lat <= r_lat + 4'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cache_mem_responder.sv
// Directed bench for cache_mem_responder: a reference-model scoreboard checks every return beat,
// with cycle-accurate handshake and latency checks on a default and a low-latency instance.
module tb_cache_mem_responder;
    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    cache_mem_responder_if if0 ();
    cache_mem_responder_if if1 ();

    cache_mem_responder u_dut0 (.clk(clk), .resetn(resetn), .bus(if0));
    cache_mem_responder #(.ADDR_W(12), .RD_LATENCY(1), .WR_LATENCY(0))
        u_dut1 (.clk(clk), .resetn(resetn), .bus(if1));

    int          n_cmp = 0;
    int          n_mis = 0;
    logic [32:0] sb0 [$];
    logic [32:0] sb1 [$];
    logic [32:0] e0, e1;
    logic [31:0] m0 [4096];
    logic [31:0] m1 [4096];

    localparam logic [2:0] T_LINE = 3'b100;
    localparam logic [2:0] T_WORD = 3'b010;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Reference memory update for instance sel (0 or 1)
    task automatic mwr(input int sel, input logic [2:0] t, input logic [31:0] a,
                       input logic [3:0] s, input logic [127:0] d);
        logic [31:0] w;
        int idx = int'(a[13:2]);
        int base = int'({a[13:4], 2'b00});
        if (t == T_LINE) begin
            for (int i = 0; i < 4; i++) begin
                if (sel == 0) m0[base+i] = d[32*i +: 32];
                else          m1[base+i] = d[32*i +: 32];
            end
        end else begin
            w = (sel == 0) ? m0[idx] : m1[idx];
            for (int j = 0; j < 4; j++) if (s[j]) w[8*j +: 8] = d[8*j +: 8];
            if (sel == 0) m0[idx] = w;
            else          m1[idx] = w;
        end
    endtask

    task automatic push_exp(input int sel, input logic [2:0] t, input logic [31:0] a);
        int idx = int'(a[13:2]);
        int base = int'({a[13:4], 2'b00});
        if (t == T_LINE) begin
            for (int i = 0; i < 4; i++) begin
                if (sel == 0) sb0.push_back({(i == 3), m0[base+i]});
                else          sb1.push_back({(i == 3), m1[base+i]});
            end
        end else begin
            if (sel == 0) sb0.push_back({1'b1, m0[idx]});
            else          sb1.push_back({1'b1, m1[idx]});
        end
    endtask

    task automatic wr0(input logic [2:0] t, input logic [31:0] a, input logic [3:0] s,
                       input logic [127:0] d);
        if0.wr_req = 1'b1; if0.wr_type = t; if0.wr_addr = a; if0.wr_wstrb = s; if0.wr_data = d;
        #1;
        for (int k = 0; k < 40 && if0.wr_rdy !== 1'b1; k++) begin @(negedge clk); #1; end
        chk1("wr0_rdy_wait", if0.wr_rdy, 1'b1);
        @(posedge clk);
        mwr(0, t, a, s, d);
        @(negedge clk);
        if0.wr_req = 1'b0;
    endtask

    task automatic rd0(input logic [2:0] t, input logic [31:0] a);
        if0.rd_req = 1'b1; if0.rd_type = t; if0.rd_addr = a;
        #1;
        for (int k = 0; k < 40 && if0.rd_rdy !== 1'b1; k++) begin @(negedge clk); #1; end
        chk1("rd0_rdy_wait", if0.rd_rdy, 1'b1);
        @(posedge clk);
        push_exp(0, t, a);
        @(negedge clk);
        if0.rd_req = 1'b0;
    endtask

    // Called in the cycle right after read acceptance on the RD_LATENCY=2 instance.
    task automatic beats0(input int nb);
        chk1("d0_valid_T", if0.ret_valid, 1'b0);
        @(negedge clk);
        chk1("d0_valid_T1", if0.ret_valid, 1'b0);
        for (int i = 0; i < nb; i++) begin
            @(negedge clk);
            chk1("d0_beat_valid", if0.ret_valid, 1'b1);
            chk1("d0_beat_last", if0.ret_last, (i == nb - 1));
        end
        @(negedge clk);
        chk1("d0_post_valid", if0.ret_valid, 1'b0);
        chk1("d0_post_last", if0.ret_last, 1'b0);
    endtask

    task automatic drain(input int sel);
        for (int k = 0; k < 40 && ((sel == 0) ? sb0.size() : sb1.size()) != 0; k++) @(negedge clk);
        chk("sb_drained", 64'((sel == 0) ? sb0.size() : sb1.size()), 64'd0);
    endtask

    always @(negedge clk) begin
        if (if0.ret_valid === 1'b1) begin
            if (sb0.size() == 0) chk("d0_unexpected_beat", 64'(sb0.size()), 64'd1);
            else begin
                e0 = sb0.pop_front();
                chk("d0_beat", 64'({if0.ret_last, if0.ret_data}), 64'(e0));
            end
        end
        if (if1.ret_valid === 1'b1) begin
            if (sb1.size() == 0) chk("d1_unexpected_beat", 64'(sb1.size()), 64'd1);
            else begin
                e1 = sb1.pop_front();
                chk("d1_beat", 64'({if1.ret_last, if1.ret_data}), 64'(e1));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0;
        if0.rd_req = 0; if0.rd_type = 0; if0.rd_addr = 0;
        if0.wr_req = 0; if0.wr_type = 0; if0.wr_addr = 0; if0.wr_wstrb = 0; if0.wr_data = 0;
        if1.rd_req = 0; if1.rd_type = 0; if1.rd_addr = 0;
        if1.wr_req = 0; if1.wr_type = 0; if1.wr_addr = 0; if1.wr_wstrb = 0; if1.wr_data = 0;
        repeat (3) @(negedge clk);

        // Reset state
        chk1("rst_rd_rdy", if0.rd_rdy, 1'b0);
        chk1("rst_wr_rdy", if0.wr_rdy, 1'b0);
        chk1("rst_ret_valid", if0.ret_valid, 1'b0);
        chk1("rst_ret_last", if0.ret_last, 1'b0);
        chk("rst_ret_data", 64'(if0.ret_data), 64'd0);
        chk1("rst_d1_valid", if1.ret_valid, 1'b0);
        resetn = 1'b1;
        @(negedge clk);
        chk1("idle_rd_rdy", if0.rd_rdy, 1'b1);
        chk1("idle_wr_rdy", if0.wr_rdy, 1'b1);

        // Line write then line read, 4 beats A..D
        wr0(T_LINE, 32'h100, 4'h0, {32'hDDDD_0004, 32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001});
        chk1("wr_busy", if0.wr_rdy, 1'b0);
        @(negedge clk);
        chk1("wr_busy_end", if0.wr_rdy, 1'b1);
        rd0(T_LINE, 32'h100);
        beats0(4);
        drain(0);
        chk("ret_data_hold", 64'(if0.ret_data), 64'h0000_0000_DDDD_0004);

        // Partial word write under strobes, single-beat word read
        wr0(T_WORD, 32'h104, 4'hF, 128'hAAAA_AAAA);
        wr0(T_WORD, 32'h104, 4'b0011, 128'h1122_3344);
        rd0(T_WORD, 32'h104);
        beats0(1);
        drain(0);
        chk("strb_merge", 64'(if0.ret_data), 64'h0000_0000_AAAA_3344);

        // Simultaneous write and read to different lines
        @(negedge clk);
        if0.wr_req = 1'b1; if0.wr_type = T_LINE; if0.wr_addr = 32'h200; if0.wr_wstrb = 4'h0;
        if0.wr_data = {32'h2000_0003, 32'h2000_0002, 32'h2000_0001, 32'h2000_0000};
        if0.rd_req = 1'b1; if0.rd_type = T_LINE; if0.rd_addr = 32'h100;
        #1;
        chk1("both_rd_rdy", if0.rd_rdy, 1'b0);
        chk1("both_wr_rdy", if0.wr_rdy, 1'b1);
        @(posedge clk);
        mwr(0, T_LINE, 32'h200, 4'h0, if0.wr_data);
        @(negedge clk);
        if0.wr_req = 1'b0;
        #1;
        chk1("both_rd_pending", if0.rd_rdy, 1'b0);
        @(negedge clk);
        #1;
        chk1("both_rd_later", if0.rd_rdy, 1'b1);
        @(posedge clk);
        push_exp(0, T_LINE, 32'h100);
        @(negedge clk);
        if0.rd_req = 1'b0;
        beats0(4);
        drain(0);
        rd0(T_LINE, 32'h200);
        beats0(4);
        drain(0);

        // Aliasing above the RAM depth
        wr0(T_WORD, 32'h0000_0010, 4'hF, 128'hCAFE_F00D);
        rd0(T_WORD, 32'h0001_0010);
        beats0(1);
        drain(0);
        chk("alias_data", 64'(if0.ret_data), 64'h0000_0000_CAFE_F00D);

        // Reset during the second beat of a line read
        rd0(T_LINE, 32'h200);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk1("mid_burst_valid", if0.ret_valid, 1'b1);
        resetn = 1'b0;
        @(negedge clk);
        chk1("abort_valid", if0.ret_valid, 1'b0);
        chk1("abort_last", if0.ret_last, 1'b0);
        chk("abort_data", 64'(if0.ret_data), 64'd0);
        chk1("abort_wr_rdy", if0.wr_rdy, 1'b0);
        sb0.delete();
        resetn = 1'b1;
        #1;
        chk1("abort_idle", if0.wr_rdy, 1'b1);
        @(negedge clk);
        chk1("abort_still_quiet", if0.ret_valid, 1'b0);
        rd0(T_LINE, 32'h100);
        beats0(4);
        drain(0);

        // RD_LATENCY=1, WR_LATENCY=0 instance: back-to-back writes, first beat at T+1
        if1.wr_req = 1'b1; if1.wr_type = T_LINE; if1.wr_addr = 32'h20; if1.wr_wstrb = 4'h0;
        if1.wr_data = {32'h5555_0003, 32'h5555_0002, 32'h5555_0001, 32'h5555_0000};
        #1;
        chk1("d1_wr_rdy0", if1.wr_rdy, 1'b1);
        @(posedge clk);
        mwr(1, T_LINE, 32'h20, 4'h0, if1.wr_data);
        @(negedge clk);
        if1.wr_type = T_WORD; if1.wr_addr = 32'h28; if1.wr_wstrb = 4'hF; if1.wr_data = 128'h1111_2222;
        #1;
        chk1("d1_wr_rdy1", if1.wr_rdy, 1'b1);
        @(posedge clk);
        mwr(1, T_WORD, 32'h28, 4'hF, if1.wr_data);
        @(negedge clk);
        if1.wr_addr = 32'h2C; if1.wr_data = 128'h3333_4444;
        #1;
        chk1("d1_wr_rdy2", if1.wr_rdy, 1'b1);
        @(posedge clk);
        mwr(1, T_WORD, 32'h2C, 4'hF, if1.wr_data);
        @(negedge clk);
        if1.wr_req = 1'b0;
        if1.rd_req = 1'b1; if1.rd_type = T_LINE; if1.rd_addr = 32'h20;
        #1;
        chk1("d1_rd_rdy", if1.rd_rdy, 1'b1);
        @(posedge clk);
        push_exp(1, T_LINE, 32'h20);
        @(negedge clk);
        if1.rd_req = 1'b0;
        chk1("d1_valid_T", if1.ret_valid, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk1("d1_beat_valid", if1.ret_valid, 1'b1);
            chk1("d1_beat_last", if1.ret_last, (i == 3));
        end
        @(negedge clk);
        chk1("d1_post_valid", if1.ret_valid, 1'b0);
        drain(1);
        chk("d1_last_word", 64'(if1.ret_data), 64'h0000_0000_3333_4444);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
